ws2812_frame_driver: RTL and testbench

- Parametrised WS2812/NZR strip driver. It holds a per-LED GRB frame buffer and streams 1..MAX_LEDS pixels per frame with gapless bit timing, followed by a latch gap.
- Supports single-shot and continuous (loop) refresh. Writes from the host side are accepted at any time.
- Replaces the fixed-pattern shift/count/bit-gen chain. It sits between the colour/control logic and the strip data pin.

---
 rtl/ws2812_pkg.sv | 25 ++
 rtl/ws2812_bit_enc.sv | 52 +++++
 rtl/ws2812_frame_driver.sv | 169 ++++++++++++++++
 tb/tb_ws2812_frame_driver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame driver and its bit encoder.
package ws2812_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BIT_HI,
    BIT_LO,
    LATCH
  } state_t;

  // GRB pixel layout: green is transmitted first, blue last
  localparam int PIX_W = 24;
  localparam int G_LSB = 16;
  localparam int R_LSB = 8;
  localparam int B_LSB = 0;

  // Default timing for a 50 MHz clock
  localparam int DEF_MAX_LEDS  = 16;
  localparam int DEF_T0H_CYC   = 20;
  localparam int DEF_T1H_CYC   = 40;
  localparam int DEF_TBIT_CYC  = 63;
  localparam int DEF_RESET_CYC = 3000;

endpackage

// File: rtl/ws2812_bit_enc.sv
// Encodes one NZR bit: a high pulse of T1H/T0H cycles, then low for the rest of
// the TBIT period. A new bit can be accepted on the last cycle of the current one,
// so back-to-back bits have no gap.
module ws2812_bit_enc
  import ws2812_pkg::*;
#(
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC,
  parameter int TBIT_CYC = DEF_TBIT_CYC,
  parameter int CW       = $clog2(TBIT_CYC + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_valid,
  input  logic bit_val,
  output logic bit_ready,
  output logic data_out
);

  logic          active;
  logic          cur_val;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] hi_len;

  assign bit_ready = !active || (cnt == CW'(TBIT_CYC - 1));
  assign cnt_nxt   = cnt + 1'b1;
  assign hi_len    = cur_val ? CW'(T1H_CYC) : CW'(T0H_CYC);

  // Bit period counter and registered line level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active   <= 1'b0;
      cur_val  <= 1'b0;
      cnt      <= '0;
      data_out <= 1'b0;
    end else if (bit_ready && bit_valid) begin
      active   <= 1'b1;
      cur_val  <= bit_val;
      cnt      <= '0;
      data_out <= 1'b1;
    end else if (bit_ready) begin
      active   <= 1'b0;
      cnt      <= '0;
      data_out <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      data_out <= (cnt_nxt < hi_len);
    end
  end

endmodule

// File: rtl/ws2812_frame_driver.sv
// WS2812 strip driver: holds a GRB frame buffer and streams 1..MAX_LEDS pixels
// per frame with gapless bit timing, followed by a latch (reset) gap.
module ws2812_frame_driver
  import ws2812_pkg::*;
#(
  parameter int MAX_LEDS  = DEF_MAX_LEDS,
  parameter int AW        = $clog2(MAX_LEDS),
  parameter int T0H_CYC   = DEF_T0H_CYC,
  parameter int T1H_CYC   = DEF_T1H_CYC,
  parameter int TBIT_CYC  = DEF_TBIT_CYC,
  parameter int RESET_CYC = DEF_RESET_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_grb,
  input  logic [AW:0]      num_leds,
  input  logic             start,
  input  logic             loop_en,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    led_idx,
  output logic             data_out
);

  localparam int TW = $clog2((TBIT_CYC > RESET_CYC ? TBIT_CYC : RESET_CYC) + 1);

  logic [PIX_W-1:0] frame_buf [MAX_LEDS];
  state_t           state;
  logic [PIX_W-2:0] shifter;
  logic [4:0]       bit_cnt;
  logic [AW:0]      led_cnt;
  logic [AW:0]      n_cap;
  logic [AW:0]      n_clamped;
  logic [TW-1:0]    latch_tmr;
  logic [AW-1:0]    next_idx;
  logic [PIX_W-1:0] cur_pix;
  logic [PIX_W-1:0] next_pix;
  logic             more_leds;
  logic             frame_req;
  logic             bit_valid;
  logic             bit_val;
  logic             bit_ready;

  assign n_clamped = (num_leds > (AW+1)'(MAX_LEDS)) ? (AW+1)'(MAX_LEDS) : num_leds;
  assign next_idx  = led_idx + 1'b1;
  assign cur_pix   = frame_buf[led_idx];
  assign next_pix  = frame_buf[next_idx];
  assign more_leds = (led_cnt < n_cap);
  assign frame_req = ((state == IDLE) && (start || loop_en)) ||
                     ((state == LATCH) && (latch_tmr == '0) && loop_en);

  // Host writes land in the buffer at any time; out-of-range addresses are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEDS; i++) frame_buf[i] <= '0;
    end else if (wr_en && ({1'b0, wr_addr} < (AW+1)'(MAX_LEDS))) begin
      frame_buf[wr_addr] <= wr_grb;
    end
  end

  // Next bit for the encoder: first bit straight from the buffer, then from the
  // shifter, and at an LED boundary the MSB of the prefetched next pixel
  always_comb begin
    bit_valid = 1'b0;
    bit_val   = 1'b0;
    case (state)
      LOAD: begin
        bit_valid = 1'b1;
        bit_val   = cur_pix[PIX_W-1];
      end
      BIT_HI, BIT_LO: begin
        if (bit_cnt != 5'd0) begin
          bit_valid = 1'b1;
          bit_val   = shifter[PIX_W-2];
        end else if (more_leds) begin
          bit_valid = 1'b1;
          bit_val   = next_pix[PIX_W-1];
        end
      end
      default: ;
    endcase
  end

  // Frame sequencing: acceptance, per-LED loading, latch gap and loop restart
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      led_idx   <= '0;
      led_cnt   <= '0;
      n_cap     <= '0;
      bit_cnt   <= '0;
      shifter   <= '0;
      latch_tmr <= '0;
    end else begin
      done <= 1'b0;
      if (frame_req) begin
        busy    <= 1'b1;
        led_idx <= '0;
        led_cnt <= '0;
        n_cap   <= n_clamped;
        if (n_clamped == '0) begin
          // An empty frame still spends one cycle where LOAD would be
          state     <= LATCH;
          latch_tmr <= TW'(RESET_CYC);
        end else begin
          state <= LOAD;
        end
      end else begin
        case (state)
          LOAD: begin
            shifter <= cur_pix[PIX_W-2:0];
            bit_cnt <= 5'd23;
            led_cnt <= (AW+1)'(1);
            state   <= BIT_HI;
          end
          BIT_HI, BIT_LO: begin
            if (bit_ready) begin
              state <= BIT_HI;
              if (bit_cnt != 5'd0) begin
                bit_cnt <= bit_cnt - 1'b1;
                shifter <= {shifter[PIX_W-3:0], 1'b0};
              end else if (more_leds) begin
                shifter <= next_pix[PIX_W-2:0];
                bit_cnt <= 5'd23;
                led_idx <= next_idx;
                led_cnt <= led_cnt + 1'b1;
              end else begin
                state     <= LATCH;
                latch_tmr <= TW'(RESET_CYC - 1);
                done      <= (RESET_CYC == 1);
              end
            end else if (!data_out) begin
              state <= BIT_LO;
            end
          end
          LATCH: begin
            if (latch_tmr != '0) begin
              latch_tmr <= latch_tmr - 1'b1;
              done      <= (latch_tmr == TW'(1));
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  ws2812_bit_enc #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .TBIT_CYC(TBIT_CYC),
    .CW      (TW)
  ) u_bit_enc (
    .clk      (clk),
    .reset    (reset),
    .bit_valid(bit_valid),
    .bit_val  (bit_val),
    .bit_ready(bit_ready),
    .data_out (data_out)
  );

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Testbench for ws2812_frame_driver: expected line waveform is computed per cycle
// from the pixel values and bit timing rules, with a buffer model that tracks
// host writes and the moment each LED is loaded.
module tb_ws2812_frame_driver;

  localparam int MAX_LEDS = 4;
  localparam int AW       = 2;
  localparam int T0H      = 2;
  localparam int T1H      = 4;
  localparam int TBIT     = 6;
  localparam int RST      = 10;
  localparam int LED_CYC  = 24 * TBIT;

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic          wr_en    = 1'b0;
  logic [AW-1:0] wr_addr  = '0;
  logic [23:0]   wr_grb   = '0;
  logic [AW:0]   num_leds = '0;
  logic          start    = 1'b0;
  logic          loop_en  = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] led_idx;
  logic          data_out;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [23:0] modelBuf [MAX_LEDS];

  typedef struct {
    int          n;
    logic [23:0] p0;
    logic [23:0] p1;
    logic [23:0] p2;
    int          wrCyc;
    int          wrAddr;
    logic [23:0] wrVal;
    int          startCyc;
    string       name;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  ws2812_frame_driver #(
    .MAX_LEDS (MAX_LEDS),
    .AW       (AW),
    .T0H_CYC  (T0H),
    .T1H_CYC  (T1H),
    .TBIT_CYC (TBIT),
    .RESET_CYC(RST)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_grb  (wr_grb),
    .num_leds(num_leds),
    .start   (start),
    .loop_en (loop_en),
    .busy    (busy),
    .done    (done),
    .led_idx (led_idx),
    .data_out(data_out)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic writePixel(input int addr, input logic [23:0] val);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_grb  = val;
    modelBuf[addr] = val;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  // Drive a frame request; the following rising edge is the acceptance edge
  task automatic applyStimulus(input int n);
    @(negedge clk);
    num_leds = (AW+1)'(n);
    start    = 1'b1;
  endtask

  // Follows one accepted frame cycle by cycle, from the cycle after the
  // acceptance edge up to and including the done cycle
  task automatic runFrame(input string name, input int n, input int wrCyc, input int wrAddr,
                          input logic [23:0] wrVal, input int startCyc, input int dropLoopCyc);
    int          total = 1 + LED_CYC * n + RST;
    logic [23:0] ledPix [MAX_LEDS];
    int          waveErr = 0, doneErr = 0, busyErr = 0, idxErr = 0;
    int          firstWave = -1, firstDone = -1, firstBusy = -1, firstIdx = -1;
    bit          pendWr = 1'b0;
    int          pendA = 0;
    logic [23:0] pendV = '0;
    int          t, led, bitPos, ph, hi, expIdx;
    logic        expData;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      start = (c == startCyc);
      wr_en = 1'b0;
      if (c >= 1 && ((c - 1) % LED_CYC) == 0 && ((c - 1) / LED_CYC) < n)
        ledPix[(c - 1) / LED_CYC] = modelBuf[(c - 1) / LED_CYC];
      if (pendWr) begin
        modelBuf[pendA] = pendV;
        pendWr = 1'b0;
      end
      expData = 1'b0;
      expIdx  = (n > 0) ? n - 1 : 0;
      if (c == 0) begin
        expIdx = 0;
      end else if (c <= LED_CYC * n) begin
        t       = c - 1;
        led     = t / LED_CYC;
        bitPos  = 23 - (t % LED_CYC) / TBIT;
        ph      = t % TBIT;
        hi      = ledPix[led][bitPos] ? T1H : T0H;
        expData = (ph < hi);
        expIdx  = led;
      end
      if (data_out !== expData) begin
        waveErr++;
        if (firstWave < 0) firstWave = c;
      end
      if (done !== (c == total - 1)) begin
        doneErr++;
        if (firstDone < 0) firstDone = c;
      end
      if (busy !== 1'b1) begin
        busyErr++;
        if (firstBusy < 0) firstBusy = c;
      end
      if (led_idx !== AW'(expIdx)) begin
        idxErr++;
        if (firstIdx < 0) firstIdx = c;
      end
      if (c == wrCyc) begin
        wr_en   = 1'b1;
        wr_addr = AW'(wrAddr);
        wr_grb  = wrVal;
        pendWr  = 1'b1;
        pendA   = wrAddr;
        pendV   = wrVal;
      end
      if (c == dropLoopCyc) loop_en = 1'b0;
    end
    start = 1'b0;
    wr_en = 1'b0;
    checkOutput($sformatf("%s data_out bad cycles (first %0d)", name, firstWave), waveErr, 0);
    checkOutput($sformatf("%s done bad cycles (first %0d)", name, firstDone), doneErr, 0);
    checkOutput($sformatf("%s busy bad cycles (first %0d)", name, firstBusy), busyErr, 0);
    checkOutput($sformatf("%s led_idx bad cycles (first %0d)", name, firstIdx), idxErr, 0);
  endtask

  // After a frame that should not be followed by another: all outputs quiet
  task automatic checkIdle(input string name, input int cycles);
    int active = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || data_out !== 1'b0) active++;
    end
    checkOutput($sformatf("%s idle cycles with activity", name), active, 0);
  endtask

  initial begin
    vecs[0] = '{1, 24'hFF0000, 24'h000000, 24'h000000, -1, 0, 24'h0, -1, "single FF0000"};
    vecs[1] = '{3, 24'h000001, 24'h800000, 24'hAAAAAA, -1, 0, 24'h0, -1, "three led gapless"};
    vecs[2] = '{2, 24'h123456, 24'h000000, 24'h000000, 30, 1, 24'h00FF00, -1, "write led1 during led0"};
    vecs[3] = '{1, 24'hA5A5A5, 24'h000000, 24'h000000, 0, 0, 24'h5A5A5A, -1, "write in load cycle"};
    vecs[4] = '{0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, -1, 0, 24'h0, 5, "empty frame start busy"};
    vecs[5] = '{2, 24'h0F0F0F, 24'hF0F0F0, 24'h000000, LED_CYC, 1, 24'h3C3C3C, 40, "write at led1 load edge"};

    for (int i = 0; i < MAX_LEDS; i++) modelBuf[i] = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset led_idx", led_idx, 0);
    checkOutput("reset data_out", data_out, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      writePixel(0, vecs[v].p0);
      writePixel(1, vecs[v].p1);
      writePixel(2, vecs[v].p2);
      applyStimulus(vecs[v].n);
      runFrame(vecs[v].name, vecs[v].n, vecs[v].wrCyc, vecs[v].wrAddr, vecs[v].wrVal,
               vecs[v].startCyc, -1);
      checkIdle(vecs[v].name, 20);
    end

    // Continuous refresh, then loop_en dropped part way through the second frame
    writePixel(0, 24'hC0FFEE);
    writePixel(1, 24'h13579B);
    @(negedge clk);
    num_leds = 3'd2;
    loop_en  = 1'b1;
    runFrame("loop frame 1", 2, -1, 0, 24'h0, -1, -1);
    runFrame("loop frame 2", 2, -1, 0, 24'h0, -1, 100);
    checkIdle("loop end", 20);

    // Randomised frames with a random host write somewhere in the frame
    for (int r = 0; r < 6; r++) begin
      int n;
      int total;
      n = $urandom_range(0, MAX_LEDS);
      for (int a = 0; a < MAX_LEDS; a++) writePixel(a, 24'($urandom));
      total = 1 + LED_CYC * n + RST;
      applyStimulus(n);
      runFrame($sformatf("random %0d n=%0d", r, n), n, $urandom_range(0, total - 1),
               $urandom_range(0, MAX_LEDS - 1), 24'($urandom), -1, -1);
      checkIdle($sformatf("random %0d", r), 3);
    end

    // Asynchronous reset during a high phase clears the line and the buffer
    writePixel(0, 24'hFFFFFF);
    writePixel(1, 24'hFFFFFF);
    applyStimulus(1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("pre-reset data_out high", data_out, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset data_out", data_out, 0);
    checkOutput("async reset busy", busy, 0);
    for (int i = 0; i < MAX_LEDS; i++) modelBuf[i] = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(2);
    runFrame("after reset zero buffer", 2, -1, 0, 24'h0, -1, -1);
    checkIdle("after reset", 10);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
